// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian host byte stream into 32-bit words, writes them to instruction memory, and releases the CPU reset when the load is complete
module imem_loader #(
  parameter int DEPTH = 7,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic             wr_en_o,
  output logic [31:0]      wr_addr_o,
  output logic [31:0]      wr_data_o,
  output logic             cpu_rst_n_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] word_count_o
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t             state_q, state_d;
  logic [1:0]         byte_q, byte_d;
  logic [CNT_W-1:0]   word_q, word_d;
  logic [31:0]        asm_q, asm_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic               wr_en_q, wr_en_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               in_ready_q, busy_q, done_q, cpu_rst_n_q;
  assign in_ready_o   = in_ready_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign cpu_rst_n_o  = cpu_rst_n_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = word_q;
  // next-state: bytes shift in from the right so the first byte ends up in [31:24]
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    word_d    = word_q;
    asm_d     = asm_q;
    last_d    = last_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = LOAD;
        err_d   = 1'b0;
        word_d  = '0;
        byte_d  = '0;
      end
      LOAD: if (in_valid_i) begin
        asm_d  = {asm_q[23:0], in_data_i};
        byte_d = byte_q + 2'd1;
        if (byte_q == 2'd3) begin
          state_d   = WRITE;
          last_d    = in_last_i;
          wr_en_d   = 1'b1;
          wr_addr_d = 32'({word_q, 2'b00});
          wr_data_d = {asm_q[23:0], in_data_i};
        end else if (in_last_i) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      WRITE: begin
        word_d  = word_q + 1'b1;
        byte_d  = '0;
        state_d = (last_q || word_q == CNT_W'(DEPTH - 1)) ? DONE : LOAD;
        err_d   = err_q | (!last_q && word_q == CNT_W'(DEPTH - 1));
      end
    endcase
  end
  // state and registered outputs; status flags are decoded from the next state so they change with it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      word_q      <= '0;
      asm_q       <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      word_q      <= word_d;
      asm_q       <= asm_d;
      last_q      <= last_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      in_ready_q  <= state_d == LOAD;
      busy_q      <= state_d == LOAD || state_d == WRITE;
      done_q      <= state_d == DONE;
      cpu_rst_n_q <= state_d == DONE;
    end
  end
endmodule
